// File: rtl/aftab_csr_seq_pkg.sv
// Shared constants, encodings and the CSR access table for the AFTAB trap/MRET sequencer.
// The table is indexed by (mode, step) so the top only decides *when* to move through it.
package aftab_csr_seq_pkg;

  localparam int CSR_ADDR_W = 12;

  localparam logic [CSR_ADDR_W-1:0] CSR_MEPC    = 12'h341;
  localparam logic [CSR_ADDR_W-1:0] CSR_MCAUSE  = 12'h342;
  localparam logic [CSR_ADDR_W-1:0] CSR_MSTATUS = 12'h300;
  localparam logic [CSR_ADDR_W-1:0] CSR_MTVEC   = 12'h305;

  localparam int TRAP_LAST  = 4;
  localparam int MRET_FIRST = 2;

  typedef enum logic [2:0] {
    SRC_NONE     = 3'd0,
    SRC_PC       = 3'd1,
    SRC_CAUSE    = 3'd2,
    SRC_MST_TRAP = 3'd3,
    SRC_MST_MRET = 3'd4
  } wr_src_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  typedef enum logic {
    MODE_TRAP = 1'b0,
    MODE_MRET = 1'b1
  } mode_e;

  typedef struct packed {
    logic [CSR_ADDR_W-1:0] addr;
    logic                  rd;
    logic                  wr;
    wr_src_e               src;
    logic                  last;
  } csr_access_t;

  // Trap entry walks steps 0..TRAP_LAST upward; MRET walks MRET_FIRST..0 downward.
  function automatic csr_access_t lookup_access(input mode_e mode, input logic [7:0] idx);
    csr_access_t a;
    a = '0;
    if (mode == MODE_TRAP) begin
      case (idx)
        8'd0: begin a.addr = CSR_MEPC;    a.wr = 1'b1; a.src = SRC_PC;       end
        8'd1: begin a.addr = CSR_MCAUSE;  a.wr = 1'b1; a.src = SRC_CAUSE;    end
        8'd2: begin a.addr = CSR_MSTATUS; a.rd = 1'b1;                       end
        8'd3: begin a.addr = CSR_MSTATUS; a.wr = 1'b1; a.src = SRC_MST_TRAP; end
        8'd4: begin a.addr = CSR_MTVEC;   a.rd = 1'b1; a.last = 1'b1;        end
        default: a = '0;
      endcase
    end else begin
      case (idx)
        8'd2: begin a.addr = CSR_MSTATUS; a.rd = 1'b1;                       end
        8'd1: begin a.addr = CSR_MSTATUS; a.wr = 1'b1; a.src = SRC_MST_MRET; end
        8'd0: begin a.addr = CSR_MEPC;    a.rd = 1'b1; a.last = 1'b1;        end
        default: a = '0;
      endcase
    end
    return a;
  endfunction

endpackage

// File: rtl/aftab_trap_step_counter.sv
// Saturating step counter: zero > load > up > down. sat_hit flags an up/down request
// that would have run past either end, which the sequencer treats as a design error.
module aftab_trap_step_counter #(
  parameter int len = 3
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           zero,
  input  logic           load,
  input  logic [len-1:0] load_val,
  input  logic           up,
  input  logic           down,
  output logic [len-1:0] cnt,
  output logic           sat_hit
);

  logic [len-1:0] cnt_q;
  logic [len-1:0] cnt_d;

  always_comb begin
    cnt_d   = cnt_q;
    sat_hit = 1'b0;
    if (zero) begin
      cnt_d = '0;
    end else if (load) begin
      cnt_d = load_val;
    end else if (up) begin
      if (cnt_q == '1) sat_hit = 1'b1;
      else             cnt_d   = cnt_q + 1'b1;
    end else if (down) begin
      if (cnt_q == '0) sat_hit = 1'b1;
      else             cnt_d   = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/aftab_csr_trap_sequencer.sv
// Drives one CSR-file access per step for trap entry (up-count) and MRET (down-count),
// holding each strobe until csrAck and pulsing a done flag once the table is exhausted.
module aftab_csr_trap_sequencer
  import aftab_csr_seq_pkg::*;
#(
  parameter int len    = 3,
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              trapReq,
  input  logic              mretReq,
  input  logic              csrAck,
  output logic [ADDR_W-1:0] csrAddr,
  output logic              csrRd,
  output logic              csrWr,
  output logic [2:0]        wrSrcSel,
  output logic              ldPC,
  output logic              busy,
  output logic              trapDone,
  output logic              mretDone,
  output logic [len-1:0]    step
);

  state_e         state_q, state_d;
  mode_e          mode_q, mode_d;
  logic [len-1:0] step_q;
  logic           cnt_zero, cnt_load, cnt_up, cnt_down, cnt_sat;
  csr_access_t    access;

  aftab_trap_step_counter #(.len(len)) u_step_counter (
    .clk      (clk),
    .rst      (rst),
    .zero     (cnt_zero),
    .load     (cnt_load),
    .load_val (len'(MRET_FIRST)),
    .up       (cnt_up),
    .down     (cnt_down),
    .cnt      (step_q),
    .sat_hit  (cnt_sat)
  );

  assign access = lookup_access(mode_q, 8'(step_q));

  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    cnt_zero = 1'b0;
    cnt_load = 1'b0;
    cnt_up   = 1'b0;
    cnt_down = 1'b0;
    csrAddr  = '0;
    csrRd    = 1'b0;
    csrWr    = 1'b0;
    wrSrcSel = 3'd0;
    ldPC     = 1'b0;
    busy     = 1'b0;
    trapDone = 1'b0;
    mretDone = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // Trap has priority; a simultaneous MRET must be held by its requester.
        if (trapReq) begin
          cnt_zero = 1'b1;
          mode_d   = MODE_TRAP;
          state_d  = ST_ACCESS;
        end else if (mretReq) begin
          cnt_load = 1'b1;
          mode_d   = MODE_MRET;
          state_d  = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        busy     = 1'b1;
        csrAddr  = ADDR_W'(access.addr);
        csrRd    = access.rd;
        csrWr    = access.wr;
        wrSrcSel = access.src;
        if (csrAck) begin
          if (access.last) begin
            ldPC    = 1'b1;
            state_d = ST_DONE;
          end else if (mode_q == MODE_TRAP) begin
            cnt_up = 1'b1;
          end else begin
            cnt_down = 1'b1;
          end
        end
      end
      ST_DONE: begin
        busy     = 1'b1;
        trapDone = (mode_q == MODE_TRAP);
        mretDone = (mode_q == MODE_MRET);
        cnt_zero = 1'b1;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      mode_q  <= MODE_TRAP;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
    end
  end

  // Every table stays strictly inside the counter range, so hitting an end means a broken table.
  always_ff @(posedge clk) begin
    if (!rst) assert (!cnt_sat);
  end

  assign step = step_q;

endmodule

// File: tb/tb_aftab_csr_trap_sequencer.sv
// Directed plus randomized-stall checks of the CSR trap/MRET sequencer against a
// per-sequence expected access list built from the CSR access rules.
module tb_aftab_csr_trap_sequencer;

  logic        clk = 1'b0;
  logic        rst, trapReq, mretReq, csrAck;
  logic [11:0] csrAddr;
  logic        csrRd, csrWr, ldPC, busy, trapDone, mretDone;
  logic [2:0]  wrSrcSel;
  logic [2:0]  step;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int stall_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  aftab_csr_trap_sequencer #(.len(3), .ADDR_W(12)) dut (
    .clk      (clk),
    .rst      (rst),
    .trapReq  (trapReq),
    .mretReq  (mretReq),
    .csrAck   (csrAck),
    .csrAddr  (csrAddr),
    .csrRd    (csrRd),
    .csrWr    (csrWr),
    .wrSrcSel (wrSrcSel),
    .ldPC     (ldPC),
    .busy     (busy),
    .trapDone (trapDone),
    .mretDone (mretDone),
    .step     (step)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Inputs change just after the rising edge; outputs are sampled on the falling edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic check_idle(input string tag);
    chk({tag, ".busy"},  busy,     0);
    chk({tag, ".rd"},    csrRd,    0);
    chk({tag, ".wr"},    csrWr,    0);
    chk({tag, ".addr"},  csrAddr,  0);
    chk({tag, ".src"},   wrSrcSel, 0);
    chk({tag, ".ldpc"},  ldPC,     0);
    chk({tag, ".tdone"}, trapDone, 0);
    chk({tag, ".mdone"}, mretDone, 0);
    chk({tag, ".step"},  step,     0);
  endtask

  // One full sequence from IDLE request to the first IDLE cycle afterwards.
  // stall_q[k] gives the number of csrAck=0 cycles before access k is acknowledged.
  task automatic run_seq(input int id, input bit is_trap, input bit both, input bit noise);
    int exp_addr[$];
    int exp_wr[$];
    int exp_src[$];
    int exp_step[$];
    int n, start_cyc, total_stall;
    string t;
    if (is_trap) begin
      exp_addr = '{32'h341, 32'h342, 32'h300, 32'h300, 32'h305};
      exp_wr   = '{1, 1, 0, 1, 0};
      exp_src  = '{1, 2, 0, 3, 0};
    end else begin
      exp_addr = '{32'h300, 32'h300, 32'h341};
      exp_wr   = '{0, 1, 0};
      exp_src  = '{0, 4, 0};
    end
    n = exp_addr.size();
    for (int k = 0; k < n; k++) exp_step.push_back(is_trap ? k : (n - 1 - k));
    total_stall = 0;
    for (int k = 0; k < n; k++) total_stall += stall_q[k];

    trapReq = is_trap;
    mretReq = !is_trap || both;
    csrAck  = 1'b0;
    sample();
    chk($sformatf("s%0d.req_busy", id), busy, 0);
    start_cyc = cyc;
    next_cycle();
    trapReq = 1'b0;
    mretReq = 1'b0;

    for (int k = 0; k < n; k++) begin
      for (int s = 0; s <= stall_q[k]; s++) begin
        csrAck = (s == stall_q[k]);
        if (noise) begin
          trapReq = 1'($urandom_range(0, 1));
          mretReq = 1'($urandom_range(0, 1));
        end
        sample();
        t = $sformatf("s%0d.a%0d.c%0d", id, k, s);
        chk({t, ".addr"}, csrAddr,  exp_addr[k]);
        chk({t, ".wr"},   csrWr,    exp_wr[k]);
        chk({t, ".rd"},   csrRd,    !exp_wr[k]);
        chk({t, ".src"},  wrSrcSel, exp_src[k]);
        chk({t, ".step"}, step,     exp_step[k]);
        chk({t, ".ldpc"}, ldPC,     (csrAck && k == n - 1));
        chk({t, ".busy"}, busy,     1);
        chk({t, ".done"}, {trapDone, mretDone}, 0);
        next_cycle();
      end
    end

    csrAck  = 1'b0;
    trapReq = 1'b0;
    mretReq = 1'b0;
    sample();
    t = $sformatf("s%0d.done", id);
    chk({t, ".tdone"},   trapDone, is_trap);
    chk({t, ".mdone"},   mretDone, !is_trap);
    chk({t, ".busy"},    busy,     1);
    chk({t, ".strobe"},  {csrRd, csrWr, ldPC}, 0);
    chk({t, ".latency"}, cyc - start_cyc, n + 1 + total_stall);
    next_cycle();
    sample();
    check_idle($sformatf("s%0d.after", id));
    $display("seq %0d: %s stalls=%p noise=%0d done after %0d cycles",
             id, is_trap ? "trap" : "mret", stall_q, noise, n + 1 + total_stall);
    next_cycle();
  endtask

  initial begin
    rst     = 1'b1;
    trapReq = 1'b0;
    mretReq = 1'b0;
    csrAck  = 1'b0;
    next_cycle();
    next_cycle();
    sample();
    check_idle("reset");
    rst = 1'b0;
    next_cycle();

    // Trap with csrAck tied high
    stall_q = '{0, 0, 0, 0, 0};
    run_seq(0, 1'b1, 1'b0, 1'b0);

    // MRET with csrAck tied high
    stall_q = '{0, 0, 0};
    run_seq(1, 1'b0, 1'b0, 1'b0);

    // Three-cycle stall on trap step 1
    stall_q = '{0, 3, 0, 0, 0};
    run_seq(2, 1'b1, 1'b0, 1'b0);

    // Both requests together, then request noise while busy
    stall_q = '{0, 0, 0, 0, 0};
    run_seq(3, 1'b1, 1'b1, 1'b1);

    // Reset in the middle of trap step 3
    trapReq = 1'b1;
    next_cycle();
    trapReq = 1'b0;
    csrAck  = 1'b1;
    next_cycle();
    next_cycle();
    next_cycle();
    sample();
    chk("rst.pre.step", step, 3);
    chk("rst.pre.wr",   csrWr, 1);
    rst = 1'b1;
    next_cycle();
    rst    = 1'b0;
    csrAck = 1'b0;
    sample();
    check_idle("rst.at");
    next_cycle();
    sample();
    check_idle("rst.later");
    $display("seq 4: trap aborted by reset at step 3");
    next_cycle();
    stall_q = '{0, 0, 0, 0, 0};
    run_seq(5, 1'b1, 1'b0, 1'b0);

    // Randomized sequences with random stalls and request noise
    for (int i = 0; i < 16; i++) begin
      stall_q.delete();
      for (int k = 0; k < 5; k++) stall_q.push_back(int'($urandom_range(0, 3)));
      run_seq(10 + i, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/aftab_csr_trap_sequencer.md
Name: aftab_csr_trap_sequencer

Overview:
- Sequences the CSR-file accesses required at trap entry (interrupt/exception accepted) and at MRET.
- Drives CSR address, read/write strobes and write-data source select, one access per step.
- A saturating up/down/load step counter indexes the access table: up-count for trap entry, down-count for MRET.
- Sits between the interrupt controller / main control unit and the CSR register file in the AFTAB datapath.

Parameters:
- len, 3, step counter width; must be >= 3 to hold step indices 0..4.
- ADDR_W, 12, CSR address width.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- trapReq  in  1  level; trap accepted, start entry sequence
- mretReq  in  1  level; MRET decoded, start return sequence
- csrAck  in  1  CSR file completes the current access this cycle
- csrAddr  out  ADDR_W  CSR address for current step
- csrRd  out  1  read strobe, held until csrAck
- csrWr  out  1  write strobe, held until csrAck
- wrSrcSel  out  3  write-data mux select: 0 none, 1 PC, 2 cause, 3 mstatus-trap (MPIE<=MIE, MIE<=0), 4 mstatus-mret (MIE<=MPIE, MPIE<=1)
- ldPC  out  1  load PC from CSR read data (final step only)
- busy  out  1  sequence in progress
- trapDone  out  1  one-cycle pulse, entry sequence finished
- mretDone  out  1  one-cycle pulse, return sequence finished
- step  out  len  current step index (debug/observability)

Behaviour:
- Reset (sync, rst=1 at posedge): state IDLE, step=0, mode=trap. All outputs 0 (csrAddr=0, wrSrcSel=0).
- States: IDLE, ACCESS, DONE.
- IDLE:
  - trapReq=1: step zeroed, mode=trap, next ACCESS.
  - else mretReq=1: step loaded with 2, mode=mret, next ACCESS.
  - Both requests high: trap wins; mretReq is ignored and the requester must hold it.
- Trap table (up-count, steps 0..4):
  - 0: write 0x341 (mepc), src 1
  - 1: write 0x342 (mcause), src 2
  - 2: read 0x300 (mstatus)
  - 3: write 0x300, src 3
  - 4: read 0x305 (mtvec), ldPC
- MRET table (down-count, steps 2..0):
  - 2: read 0x300
  - 1: write 0x300, src 4
  - 0: read 0x341, ldPC
- ACCESS:
  - Outputs are combinational from (mode, step).
  - Strobe is held while csrAck=0; no timeout.
  - csrAck=1 on a non-final step: step +1 (trap) or -1 (mret) at the next edge; stay in ACCESS.
  - csrAck=1 on the final step (trap step 4 / mret step 0): ldPC=1 in that same cycle, then next DONE.
  - ldPC is never asserted without csrAck.
- DONE:
  - trapDone or mretDone =1 for exactly one cycle; busy=1; strobes 0.
  - step is zeroed; next IDLE.
- busy = 1 in ACCESS and DONE, 0 in IDLE.
- Requests arriving while busy are ignored; there is no queuing.
- Latency with csrAck tied high:
  - trap: request at cycle N, accesses N+1..N+5, trapDone N+6.
  - mret: accesses N+1..N+3, mretDone N+4.
- Counter saturates and never wraps: up stops at all-ones, down stops at 0. Reaching saturation inside a table is a design error and is flagged by an assertion.
- Exactly one of csrRd/csrWr is high in ACCESS; both are 0 elsewhere.
- rst mid-sequence: immediate return to IDLE at that edge. No done pulse; partial CSR writes are not undone.

Decomposition:
- Package aftab_csr_seq_pkg holds:
  - CSR address constants: MEPC 0x341, MCAUSE 0x342, MSTATUS 0x300, MTVEC 0x305
  - wrSrcSel encodings (0..4)
  - state encoding
  - final-step constants TRAP_LAST=4, MRET_FIRST=2
- Sub-module aftab_trap_step_counter: len-bit counter with zero/load/up/down controls, priority zero>load>up>down, saturating, synchronous reset.

Test Plan:
- Trap entry, csrAck tied 1, trapReq pulse at cycle 0:
  - cycles 1..5 see addr 0x341W/src1, 0x342W/src2, 0x300R, 0x300W/src3, 0x305R+ldPC
  - trapDone=1 at cycle 6 only; busy 0 at cycle 7.
- MRET with csrAck tied 1:
  - addr 0x300R, 0x300W/src4, 0x341R+ldPC on cycles 1..3
  - step 2,1,0; mretDone at cycle 4.
- csrAck stalled 3 cycles on trap step 1:
  - csrWr, csrAddr=0x342 and step=1 stable for 4 cycles, then advance
  - trapDone delayed by exactly 3 cycles.
- trapReq and mretReq asserted together in IDLE: trap sequence runs. mretReq pulsed while busy: no effect; busy drops after trapDone.
- rst=1 during trap step 3: next cycle all outputs 0, step=0, IDLE; no trapDone; a new trapReq restarts at step 0.
